// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM memory controller: FSM state
// encoding, default parameter values and half-word select helpers.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_LO = 3'd1,
        S_WR_HI = 3'd2,
        S_RD_LO = 3'd3,
        S_RD_HI = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam int unsigned DEF_ADDR_BASE     = 1024;
    localparam int unsigned DEF_SRAM_AW       = 18;
    localparam int unsigned DEF_ACCESS_CYCLES = 2;

    // Half-word select appended below the word index on the SRAM address.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    function automatic logic is_write(state_e s);
        return (s == S_WR_LO) || (s == S_WR_HI);
    endfunction

    function automatic logic is_read(state_e s);
        return (s == S_RD_LO) || (s == S_RD_HI);
    endfunction

    function automatic logic is_phase(state_e s);
        return is_write(s) || is_read(s);
    endfunction

    function automatic logic half_sel(state_e s);
        return ((s == S_WR_HI) || (s == S_RD_HI)) ? HALF_HI : HALF_LO;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Counts the clocks of one half-word phase and flags its last cycle.
// The count restarts at zero after the last cycle and whenever no phase runs,
// so every phase lasts exactly ACCESS_CYCLES clocks.
module sram_phase_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic last_o,
    output logic last_next_o
);

    localparam int unsigned    CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o      = (cnt_q == CNT_LAST);
    // Lets the controller register strobes that depend on next cycle's position.
    assign last_next_o = (cnt_d == CNT_LAST);

    // Advance inside a phase, wrap to zero after its last cycle or when idle.
    always_comb begin
        cnt_d = '0;
        if (run_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into a low and a high half-word
// access on a 16-bit asynchronous SRAM, holding ready low while busy.
// Pad controls are registered from the next state so the pins never glitch.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE     = DEF_ADDR_BASE,
    parameter int unsigned SRAM_AW       = DEF_SRAM_AW,
    parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    state_e             state_q;
    state_e             state_d;
    logic               last;
    logic               last_next;

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_idx;
    logic               unused_offset_bits;

    logic [SRAM_AW-1:0] addr_q,   addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q,  dq_oe_d;
    logic               we_n_q,   we_n_d;
    logic               oe_n_q,   oe_n_d;
    logic [15:0]        lo_q;
    logic [31:0]        read_data_q;

    // Byte address -> word index; upper bits drop so the index wraps.
    assign offset             = address - 32'(ADDR_BASE);
    assign word_idx           = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    sram_phase_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (is_phase(state_q)),
        .last_o      (last),
        .last_next_o (last_next)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: writes take priority, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (MEM_W_EN) begin
                    state_d = S_WR_LO;
                end else if (MEM_R_EN) begin
                    state_d = S_RD_LO;
                end
            end
            S_WR_LO: if (last) state_d = S_WR_HI;
            S_WR_HI: if (last) state_d = S_DONE;
            S_RD_LO: if (last) state_d = S_RD_HI;
            S_RD_HI: if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready = ((state_q == S_IDLE) && !MEM_R_EN && !MEM_W_EN) || (state_q == S_DONE);

    // Pad values for the coming cycle; the write strobe rises on each phase's last cycle.
    always_comb begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = is_write(state_d);
        we_n_d   = !(is_write(state_d) && !last_next);
        oe_n_d   = !is_read(state_d);
        if (is_phase(state_d)) begin
            addr_d = {word_idx, half_sel(state_d)};
        end
        if (is_write(state_d)) begin
            dq_out_d = (half_sel(state_d) == HALF_HI) ? write_data[31:16] : write_data[15:0];
        end
    end

    // Registered pad controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
        end else begin
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
        end
    end

    // Hold the low half until the high half arrives.
    always_ff @(posedge clk) begin
        if ((state_q == S_RD_LO) && last) begin
            lo_q <= sram_dq_in;
        end
    end

    // Assemble the load result as the high half is sampled (entry to DONE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if ((state_q == S_RD_HI) && last) begin
            read_data_q <= {sram_dq_in, lo_q};
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: a transaction-level model checked every
// cycle against the default-parameter instance, directed literal checks, and
// a second instance with single-cycle phases.
module tb_sram_mem_controller;

    localparam int AC   = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance (ACCESS_CYCLES = 2)
    logic        r, w;
    logic [31:0] address, wd;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    // Single-cycle-phase instance
    logic        r1, w1;
    logic [31:0] addr1, wd1;
    logic [31:0] read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1, sram_oe_n1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sram_mem_controller #(.ADDR_BASE(BASE), .SRAM_AW(18), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r), .MEM_W_EN(w), .address(address),
        .write_data(wd), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_mem_controller #(.ADDR_BASE(BASE), .SRAM_AW(18), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .address(addr1),
        .write_data(wd1), .read_data(read_data1), .ready(ready1), .sram_addr(sram_addr1),
        .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1),
        .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
    );

    initial forever #5 clk = ~clk;

    // SRAM for the default instance: asynchronous read, write while strobed and driven.
    logic [15:0] mem [0:(1<<18)-1];
    assign sram_dq_in = mem[sram_addr];
    initial forever begin
        @(posedge clk);
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
    end

    // Fixed pattern for the second instance: upper nibble = address low nibble.
    assign sram_dq_in1 = {sram_addr1[3:0], 12'hA5C};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: m_pos = -1 idle, 0..2*AC-1 phase cycle index, 2*AC done.
    int          m_pos = -1;
    bit          m_wr;
    logic [16:0] m_idx;
    logic [31:0] m_wd;
    logic [15:0] m_lo;
    logic [31:0] m_rd   = '0;
    logic [17:0] m_addr = '0;
    logic [15:0] m_dq   = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pos = -1; m_rd = '0; m_addr = '0; m_dq = '0;
        end else begin
            if (m_pos < 0) begin
                if (w || r) begin
                    m_pos = 0;
                    m_wr  = w;
                    m_idx = 17'((address - 32'(BASE)) >> 2);
                    m_wd  = wd;
                end
            end else if (m_pos < 2*AC) begin
                if (!m_wr && (m_pos % AC) == AC-1) begin
                    if (m_pos < AC) m_lo = sram_dq_in;
                    else            m_rd = {sram_dq_in, m_lo};
                end
                m_pos++;
            end else begin
                m_pos = -1;
            end
            if (m_pos >= 0 && m_pos < 2*AC) begin
                m_addr = {m_idx, m_pos >= AC};
                if (m_wr) m_dq = (m_pos >= AC) ? m_wd[31:16] : m_wd[15:0];
            end
        end
    end

    // Per-cycle compare of every output of the default instance against the model.
    bit e_rdy, e_ph, e_oe, e_oen, e_wen;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_rdy = (m_pos < 0) ? !(r || w) : (m_pos == 2*AC);
            e_ph  = (m_pos >= 0) && (m_pos < 2*AC);
            e_oe  = e_ph && m_wr;
            e_oen = !(e_ph && !m_wr);
            e_wen = !(e_ph && m_wr && ((m_pos % AC) != AC-1));
            chk("ready",       32'(ready),       32'(e_rdy));
            chk("sram_addr",   32'(sram_addr),   32'(m_addr));
            chk("sram_dq_out", 32'(sram_dq_out), 32'(m_dq));
            chk("sram_dq_oe",  32'(sram_dq_oe),  32'(e_oe));
            chk("sram_we_n",   32'(sram_we_n),   32'(e_wen));
            chk("sram_oe_n",   32'(sram_oe_n),   32'(e_oen));
            chk("read_data",   read_data,        m_rd);
        end
    end

    // Per-cycle snapshots of one transaction, index 0 = request cycle.
    logic [17:0] addr_log [0:63];
    logic [15:0] dq_log   [0:63];
    logic        wen_log  [0:63];
    logic        oen_log  [0:63];
    logic        doe_log  [0:63];

    // Issue one request at posedge+1, count ready-low cycles (bounded), return
    // one cycle after DONE with the request still driven.
    task automatic do_op(input bit sel, input bit wen, input bit ren, input logic [31:0] a,
                         input logic [31:0] d, output int n, output logic [31:0] rd_done);
        if (sel) begin w1 = wen; r1 = ren; addr1 = a; wd1 = d; end
        else     begin w  = wen; r  = ren; address = a; wd = d; end
        n = 0;
        #1;
        while (!(sel ? ready1 : ready) && n < 40) begin
            addr_log[n] = sel ? sram_addr1   : sram_addr;
            dq_log[n]   = sel ? sram_dq_out1 : sram_dq_out;
            wen_log[n]  = sel ? sram_we_n1   : sram_we_n;
            oen_log[n]  = sel ? sram_oe_n1   : sram_oe_n;
            doe_log[n]  = sel ? sram_dq_oe1  : sram_dq_oe;
            n++;
            @(posedge clk); #2;
        end
        rd_done = sel ? read_data1 : read_data;
        @(posedge clk); #1;
    endtask

    task automatic clear_req();
        w = 1'b0; r = 1'b0; w1 = 1'b0; r1 = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          n;
    logic [31:0] rdd;

    initial begin
        rst = 1'b1;
        w = 0; r = 0; address = 0; wd = 0;
        w1 = 0; r1 = 0; addr1 = 0; wd1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst ready",     32'(ready),     32'd1);
        chk("rst we_n",      32'(sram_we_n), 32'd1);
        chk("rst read_data", read_data,      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Store 0xDEADBEEF @1028 -> half-words 2 and 3
        do_op(0, 1, 0, 32'd1028, 32'hDEADBEEF, n, rdd);
        clear_req();
        chk("st ready low cycles", 32'(n), 32'd5);
        chk("st lo addr",  32'(addr_log[1]), 32'd2);
        chk("st lo dq",    32'(dq_log[1]),   32'hBEEF);
        chk("st lo we_n",  32'(wen_log[1]),  32'd0);
        chk("st lo hold",  32'(wen_log[2]),  32'd1);
        chk("st hi addr",  32'(addr_log[3]), 32'd3);
        chk("st hi dq",    32'(dq_log[3]),   32'hDEAD);
        chk("mem[2]",      32'(mem[2]),      32'hBEEF);
        chk("mem[3]",      32'(mem[3]),      32'hDEAD);
        @(posedge clk); #1;

        // Load it back
        do_op(0, 0, 1, 32'd1028, 32'h0, n, rdd);
        clear_req();
        chk("ld ready low cycles", 32'(n), 32'd5);
        chk("ld oe_n",     32'(oen_log[1]), 32'd0);
        chk("ld data",     rdd,             32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        chk("ld data held", read_data, 32'hDEADBEEF);

        // Both requests: write wins, read_data untouched
        do_op(0, 1, 1, 32'd1024, 32'h12345678, n, rdd);
        clear_req();
        chk("both ready low cycles", 32'(n), 32'd5);
        chk("both oe_n",   32'(oen_log[1]), 32'd1);
        chk("both dq_oe",  32'(doe_log[1]), 32'd1);
        chk("both rd kept", rdd,            32'hDEADBEEF);
        chk("mem[0]",      32'(mem[0]),     32'h5678);
        chk("mem[1]",      32'(mem[1]),     32'h1234);
        @(posedge clk); #1;

        // Address wrap, then back-to-back load of the wrapped word
        do_op(0, 1, 0, 32'(BASE + 4 * (1 << 17)), 32'hCAFEF00D, n, rdd);
        chk("wrap lo addr", 32'(addr_log[1]), 32'd0);
        chk("wrap lo dq",   32'(dq_log[1]),   32'hF00D);
        chk("wrap hi addr", 32'(addr_log[3]), 32'd1);
        do_op(0, 0, 1, 32'd1024, 32'h0, n, rdd);
        clear_req();
        chk("b2b ready low cycles", 32'(n), 32'd5);
        chk("wrap ld data", rdd, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Single-cycle phases: store then back-to-back load
        do_op(1, 1, 0, 32'd1036, 32'h55667788, n, rdd);
        chk("ac1 st ready low", 32'(n),           32'd3);
        chk("ac1 lo addr",      32'(addr_log[1]), 32'd6);
        chk("ac1 lo dq",        32'(dq_log[1]),   32'h7788);
        chk("ac1 we_n",         32'(wen_log[1]),  32'd1);
        chk("ac1 dq_oe",        32'(doe_log[1]),  32'd1);
        chk("ac1 hi addr",      32'(addr_log[2]), 32'd7);
        chk("ac1 hi dq",        32'(dq_log[2]),   32'h5566);
        do_op(1, 0, 1, 32'd1044, 32'h0, n, rdd);
        clear_req();
        chk("ac1 ld ready low", 32'(n), 32'd3);
        chk("ac1 ld data",      rdd,    32'hBA5CAA5C);
        @(posedge clk); #1;

        // Reset in the middle of WR_HI
        w = 1'b1; address = 32'd1032; wd = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-rst addr", 32'(sram_addr), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid rst addr",      32'(sram_addr),   32'd0);
        chk("mid rst dq",        32'(sram_dq_out), 32'd0);
        chk("mid rst dq_oe",     32'(sram_dq_oe),  32'd0);
        chk("mid rst we_n",      32'(sram_we_n),   32'd1);
        chk("mid rst oe_n",      32'(sram_oe_n),   32'd1);
        chk("mid rst read_data", read_data,        32'd0);
        chk("mid rst ready",     32'(ready),       32'd0);
        @(posedge clk); #1;
        w = 1'b0;
        #1;
        chk("rst ready after drop", 32'(ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle after rst", 32'(ready), 32'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
